// File: rtl/md4_padder_pkg.sv
// Shared constants and state type for the MD4 message padder.
package md4_padder_pkg;

  localparam int unsigned BLK_W       = 512;
  localparam int unsigned BLK_BYTES   = 64;
  localparam int unsigned PTR_W       = 6;
  localparam int unsigned WORD_W      = 32;
  localparam int unsigned LEN_BITS    = 64;
  localparam logic [7:0]  PAD_BYTE    = 8'h80;
  localparam int unsigned LEN_OFFSET  = 56;
  localparam int unsigned LEN_LO_WORD = 14;
  localparam int unsigned LEN_HI_WORD = 15;

  typedef enum logic [1:0] {
    S_FILL = 2'd0,
    S_EMIT = 2'd1,
    S_PADX = 2'd2
  } state_t;

endpackage

// File: rtl/md4_len_insert.sv
// Overwrites words 14 (low) and 15 (high) of a block with the 64-bit message bit length.
module md4_len_insert
  import md4_padder_pkg::*;
(
  input  logic [BLK_W-1:0]    data,
  input  logic [LEN_BITS-1:0] len,
  output logic [BLK_W-1:0]    blk_c
);

  // Length words replace whatever the buffer holds at the tail of the block.
  always_comb begin
    blk_c = data;
    blk_c[LEN_LO_WORD*WORD_W +: WORD_W] = len[WORD_W-1:0];
    blk_c[LEN_HI_WORD*WORD_W +: WORD_W] = len[LEN_BITS-1:WORD_W];
  end

endmodule

// File: rtl/md4_padder.sv
// MD4 message padder: packs bytes into 512-bit little-endian blocks, appends 0x80,
// zero fill and the 64-bit bit length, spilling into an extra block when needed.
// Optional feature: define MD4_PADDER_CNT_EN to add the blk_count output.
module md4_padder
  import md4_padder_pkg::*;
#(
  parameter int unsigned LEN_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             in_last,
  output logic             blk_valid,
  input  logic             blk_ready,
  output logic [BLK_W-1:0] blk_data,
  output logic             blk_last
`ifdef MD4_PADDER_CNT_EN
  ,
  output logic [31:0]      blk_count
`endif
);

  state_t              state_q;
  logic [PTR_W-1:0]    ptr_q;
  logic [LEN_W-1:0]    cnt_q;
  logic [BLK_W-1:0]    buf_q;
  logic                pend_q;
  logic                pad80_q;

  logic                accept_c;
  logic                blk_hs_c;
  logic                short_c;
  logic                full_c;
  logic [LEN_W-1:0]    cnt_nxt_c;
  logic [BLK_W-1:0]    wr_buf_c;
  logic [BLK_W-1:0]    pad_buf_c;
  logic [BLK_W-1:0]    xtra_c;
  logic [BLK_W-1:0]    ins_data_c;
  logic [LEN_BITS-1:0] ins_len_c;
  logic [BLK_W-1:0]    ins_blk_c;

  // Byte write, pad-byte placement and length-insert source selection.
  always_comb begin
    accept_c  = (state_q == S_FILL) && in_valid && in_ready;
    blk_hs_c  = blk_valid && blk_ready;
    short_c   = ptr_q < PTR_W'(LEN_OFFSET - 1);
    full_c    = ptr_q == PTR_W'(BLK_BYTES - 1);
    cnt_nxt_c = cnt_q + LEN_W'(8);
    wr_buf_c  = buf_q;
    wr_buf_c[{ptr_q, 3'b000} +: 8] = in_data;
    pad_buf_c = wr_buf_c;
    if (!full_c) begin
      pad_buf_c[{ptr_q + PTR_W'(1), 3'b000} +: 8] = PAD_BYTE;
    end
    xtra_c = '0;
    if (pad80_q) begin
      xtra_c[7:0] = PAD_BYTE;
    end
    ins_data_c = (state_q == S_PADX) ? xtra_c : pad_buf_c;
    ins_len_c  = (state_q == S_PADX) ? LEN_BITS'(cnt_q) : LEN_BITS'(cnt_nxt_c);
  end

  md4_len_insert u_len_insert (
    .data  (ins_data_c),
    .len   (ins_len_c),
    .blk_c (ins_blk_c)
  );

  // Control FSM with registered handshake outputs and block register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FILL;
      ptr_q     <= '0;
      cnt_q     <= '0;
      buf_q     <= '0;
      pend_q    <= 1'b0;
      pad80_q   <= 1'b0;
      in_ready  <= 1'b0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      blk_data  <= '0;
    end else begin
      case (state_q)
        S_FILL: begin
          in_ready <= 1'b1;
          if (accept_c) begin
            cnt_q <= cnt_nxt_c;
            if (in_last || full_c) begin
              buf_q     <= '0;
              ptr_q     <= '0;
              state_q   <= S_EMIT;
              blk_valid <= 1'b1;
              in_ready  <= 1'b0;
              if (!in_last) begin
                blk_data <= wr_buf_c;
                blk_last <= 1'b0;
                pend_q   <= 1'b0;
                pad80_q  <= 1'b0;
              end else if (short_c) begin
                blk_data <= ins_blk_c;
                blk_last <= 1'b1;
                pend_q   <= 1'b0;
                pad80_q  <= 1'b0;
              end else if (!full_c) begin
                blk_data <= pad_buf_c;
                blk_last <= 1'b0;
                pend_q   <= 1'b1;
                pad80_q  <= 1'b0;
              end else begin
                blk_data <= wr_buf_c;
                blk_last <= 1'b0;
                pend_q   <= 1'b1;
                pad80_q  <= 1'b1;
              end
            end else begin
              buf_q <= wr_buf_c;
              ptr_q <= ptr_q + PTR_W'(1);
            end
          end
        end
        S_EMIT: begin
          if (blk_hs_c) begin
            blk_valid <= 1'b0;
            if (blk_last) begin
              cnt_q <= '0;
            end
            if (pend_q) begin
              state_q <= S_PADX;
            end else begin
              state_q  <= S_FILL;
              in_ready <= 1'b1;
            end
          end
        end
        S_PADX: begin
          blk_data  <= ins_blk_c;
          blk_last  <= 1'b1;
          blk_valid <= 1'b1;
          pend_q    <= 1'b0;
          pad80_q   <= 1'b0;
          state_q   <= S_EMIT;
        end
        default: begin
          state_q  <= S_FILL;
          in_ready <= 1'b0;
        end
      endcase
    end
  end

`ifdef MD4_PADDER_CNT_EN
  // Free-running count of completed block handshakes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blk_count <= '0;
    end else if (blk_hs_c) begin
      blk_count <= blk_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_md4_padder.sv
// Directed bench for md4_padder (build with or without MD4_PADDER_CNT_EN).
module tb_md4_padder;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [7:0]   in_data;
  logic         in_last;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_last;
`ifdef MD4_PADDER_CNT_EN
  logic [31:0]  blk_count;
`endif

  int total;
  int bad;
  int exp_cnt;

  md4_padder #(.LEN_W(64)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .blk_valid (blk_valid),
    .blk_ready (blk_ready),
    .blk_data  (blk_data),
    .blk_last  (blk_last)
`ifdef MD4_PADDER_CNT_EN
    ,
    .blk_count (blk_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic push_byte(input logic [7:0] d, input logic l);
    int n;
    n = 0;
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL push_timeout in_ready=%b required=1", in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic get_block(output logic [511:0] d, output logic l);
    int n;
    n = 0;
    @(negedge clk);
    while (!blk_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (!blk_valid) begin
      bad++;
      $display("FAIL blk_timeout blk_valid=%b required=1", blk_valid);
    end
    d = blk_data;
    l = blk_last;
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    exp_cnt++;
  endtask

  task automatic send_zeros(input int n);
    for (int i = 0; i < n; i++) push_byte(8'h00, (i == n - 1));
  endtask

  task automatic send_abc();
    push_byte(8'h61, 1'b0);
    push_byte(8'h62, 1'b0);
    push_byte(8'h63, 1'b1);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if (in_ready !== 1'b0 || blk_valid !== 1'b0 || blk_last !== 1'b0) begin
      bad++;
      $display("FAIL reset_ctrl got rdy=%b vld=%b last=%b required 0/0/0", in_ready, blk_valid, blk_last);
    end
    total++;
    if (blk_data !== 512'd0) begin
      bad++;
      $display("FAIL reset_data got=%h required=0", blk_data);
    end
`ifdef MD4_PADDER_CNT_EN
    total++;
    if (blk_count !== 32'd0) begin
      bad++;
      $display("FAIL reset_count got=%0d required=0", blk_count);
    end
`endif
    rst_n = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL post_reset_ready got=%b required=1", in_ready);
    end
  endtask

  task automatic test_abc();
    logic [511:0] d, e;
    logic l;
    send_abc();
    get_block(d, l);
    e = '0;
    e[31:0] = 32'h80636261;
    e[14*32 +: 32] = 32'h00000018;
    total++;
    if (d !== e || l !== 1'b1) begin
      bad++;
      $display("FAIL abc got last=%b data=%h required last=1 data=%h", l, d, e);
    end
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
      bad++;
      $display("FAIL abc_return got rdy=%b vld=%b required 1/0", in_ready, blk_valid);
    end
  endtask

  task automatic test_len55();
    logic [511:0] d, e;
    logic l;
    send_zeros(55);
    get_block(d, l);
    e = '0;
    e[13*32 +: 32] = 32'h80000000;
    e[14*32 +: 32] = 32'h000001B8;
    total++;
    if (d !== e || l !== 1'b1) begin
      bad++;
      $display("FAIL len55 got last=%b data=%h required last=1 data=%h", l, d, e);
    end
  endtask

  task automatic test_len56();
    logic [511:0] d, e;
    logic l;
    send_zeros(56);
    get_block(d, l);
    e = '0;
    e[14*32 +: 32] = 32'h00000080;
    total++;
    if (d !== e || l !== 1'b0) begin
      bad++;
      $display("FAIL len56_blk1 got last=%b data=%h required last=0 data=%h", l, d, e);
    end
    get_block(d, l);
    e = '0;
    e[14*32 +: 32] = 32'h000001C0;
    total++;
    if (d !== e || l !== 1'b1) begin
      bad++;
      $display("FAIL len56_blk2 got last=%b data=%h required last=1 data=%h", l, d, e);
    end
  endtask

  task automatic test_len64();
    logic [511:0] d, e;
    logic l;
    send_zeros(64);
    get_block(d, l);
    total++;
    if (d !== 512'd0 || l !== 1'b0) begin
      bad++;
      $display("FAIL len64_blk1 got last=%b data=%h required last=0 data=0", l, d);
    end
    get_block(d, l);
    e = '0;
    e[31:0] = 32'h00000080;
    e[14*32 +: 32] = 32'h00000200;
    total++;
    if (d !== e || l !== 1'b1) begin
      bad++;
      $display("FAIL len64_blk2 got last=%b data=%h required last=1 data=%h", l, d, e);
    end
`ifdef MD4_PADDER_CNT_EN
    @(negedge clk);
    total++;
    if (blk_count !== 32'(exp_cnt)) begin
      bad++;
      $display("FAIL count_len64 got=%0d required=%0d", blk_count, exp_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    logic [511:0] d1, d2, e1, e2;
    logic l1, l2;
    fork
      begin
        for (int i = 0; i < 67; i++) push_byte(8'h61, (i == 66));
      end
      begin
        get_block(d1, l1);
        get_block(d2, l2);
      end
    join
    e1 = {64{8'h61}};
    e2 = '0;
    e2[31:0] = 32'h80616161;
    e2[14*32 +: 32] = 32'h00000218;
    total++;
    if (d1 !== e1 || l1 !== 1'b0) begin
      bad++;
      $display("FAIL b2b_blk1 got last=%b data=%h required last=0 data=%h", l1, d1, e1);
    end
    total++;
    if (d2 !== e2 || l2 !== 1'b1) begin
      bad++;
      $display("FAIL b2b_blk2 got last=%b data=%h required last=1 data=%h", l2, d2, e2);
    end
  endtask

  task automatic test_stall();
    logic [511:0] e;
    int n;
    e = '0;
    e[31:0] = 32'h80636261;
    e[14*32 +: 32] = 32'h00000018;
    send_abc();
    n = 0;
    @(negedge clk);
    while (!blk_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    // Junk input offered while the padder is busy must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hFF;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      total++;
      if (blk_valid !== 1'b1 || blk_data !== e || in_ready !== 1'b0 || blk_last !== 1'b1) begin
        bad++;
        $display("FAIL stall_hold cyc=%0d got vld=%b rdy=%b last=%b data=%h required 1/0/1 data=%h",
                 c, blk_valid, in_ready, blk_last, blk_data, e);
      end
      @(negedge clk);
    end
    in_valid  = 1'b0;
    in_last   = 1'b0;
    blk_ready = 1'b1;
    @(posedge clk);
    #1;
    blk_ready = 1'b0;
    exp_cnt++;
    total++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL stall_release got vld=%b rdy=%b required 0/1", blk_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d, e;
    logic l;
    for (int i = 0; i < 20; i++) push_byte(8'h11, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    exp_cnt = 0;
    total++;
    if (blk_valid !== 1'b0 || in_ready !== 1'b0 || blk_data !== 512'd0) begin
      bad++;
      $display("FAIL mid_reset got vld=%b rdy=%b data=%h required 0/0/0", blk_valid, in_ready, blk_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    send_abc();
    get_block(d, l);
    e = '0;
    e[31:0] = 32'h80636261;
    e[14*32 +: 32] = 32'h00000018;
    total++;
    if (d !== e || l !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_abc got last=%b data=%h required last=1 data=%h", l, d, e);
    end
`ifdef MD4_PADDER_CNT_EN
    @(negedge clk);
    total++;
    if (blk_count !== 32'd1) begin
      bad++;
      $display("FAIL mid_reset_count got=%0d required=1", blk_count);
    end
`endif
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    exp_cnt   = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_last   = 1'b0;
    blk_ready = 1'b0;
    test_reset();
    test_abc();
    test_len55();
    test_len56();
    test_len64();
    test_back_to_back();
    test_stall();
    test_abc();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
